// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between the ALU decoder, the execute
// unit and the downstream consumer.
interface alu_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_Control;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    modport master (
        output in_valid,
        output ALU_Control,
        output SrcA,
        output SrcB,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ALUResult,
        input  Zero,
        input  Illegal
    );

    modport slave (
        input  in_valid,
        input  ALU_Control,
        input  SrcA,
        input  SrcB,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ALUResult,
        output Zero,
        output Illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: single-cycle base ops plus a 32-iteration
// radix-2 shift-add multiplier for MUL/MULH, behind valid/ready handshakes.
//
// state | meaning
// IDLE  | in_ready=1, waiting to accept an operation
// MUL   | one shift-add iteration per cycle on the magnitudes
// FIX   | apply product sign, select low/high word
// RESP  | out_valid=1, result held until out_ready
module alu_exec_unit (
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULH = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic        sign_q, sign_d;
    logic        hi_sel_q, hi_sel_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;

    logic [31:0] alu_res;
    logic        alu_ill;
    logic        is_mul;
    logic [4:0]  shamt;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] addend;
    logic [32:0] sum;
    logic [63:0] acc_step;
    logic [63:0] prod_signed;
    logic [31:0] mul_res;

    assign shamt  = bus.SrcB[4:0];
    assign is_mul = (bus.ALU_Control == OP_MUL) || (bus.ALU_Control == OP_MULH);

    always_comb begin
        alu_res = 32'd0;
        alu_ill = 1'b0;
        case (bus.ALU_Control)
            OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_SLT:  alu_res = ($signed(bus.SrcA) < $signed(bus.SrcB)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_res = (bus.SrcA < bus.SrcB) ? 32'd1 : 32'd0;
            OP_SLL:  alu_res = bus.SrcA << shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
            OP_SRL:  alu_res = bus.SrcA >> shamt;
            OP_MUL, OP_MULH: alu_res = 32'd0;
            default: begin
                alu_res = 32'd0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // Magnitude of the most negative value wraps back to 0x80000000, which is
    // still the correct unsigned magnitude.
    assign abs_a = bus.SrcA[31] ? (~bus.SrcA + 32'd1) : bus.SrcA;
    assign abs_b = bus.SrcB[31] ? (~bus.SrcB + 32'd1) : bus.SrcB;

    // Add into the upper half and shift the whole accumulator right; after 32
    // steps the accumulator holds the full 64-bit magnitude product.
    assign addend   = mag_b_q[0] ? mag_a_q : 32'd0;
    assign sum      = {1'b0, acc_q[63:32]} + {1'b0, addend};
    assign acc_step = {sum, acc_q[31:1]};

    assign prod_signed = sign_q ? (~acc_q + 64'd1) : acc_q;
    assign mul_res     = hi_sel_q ? prod_signed[63:32] : prod_signed[31:0];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        hi_sel_d  = hi_sel_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_mul) begin
                        mag_a_d  = abs_a;
                        mag_b_d  = abs_b;
                        sign_d   = bus.SrcA[31] ^ bus.SrcB[31];
                        hi_sel_d = bus.ALU_Control[0];
                        acc_d    = 64'd0;
                        count_d  = 5'd0;
                        state_d  = S_MUL;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == 32'd0);
                        illegal_d = alu_ill;
                        state_d   = S_RESP;
                    end
                end
            end
            S_MUL: begin
                acc_d   = acc_step;
                mag_b_d = {1'b0, mag_b_q[31:1]};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d  = mul_res;
                zero_d    = (mul_res == 32'd0);
                illegal_d = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            mag_a_q   <= 32'd0;
            mag_b_q   <= 32'd0;
            acc_q     <= 64'd0;
            sign_q    <= 1'b0;
            hi_sel_q  <= 1'b0;
            result_q  <= 32'd0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            hi_sel_q  <= hi_sel_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: base ops, multiply latency, backpressure,
// mid-multiply reset and unsupported codes.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    alu_exec_unit_if ifc();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    // Present an op in IDLE and return 1ns after the accepting edge; operands
    // are then scrambled so stale inputs cannot leak into the result.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ifc.in_valid    = 1'b1;
        ifc.ALU_Control = c;
        ifc.SrcA        = a;
        ifc.SrcB        = b;
        @(posedge clk);
        #1;
        ifc.in_valid    = 1'b0;
        ifc.ALU_Control = 4'($urandom);
        ifc.SrcA        = $urandom;
        ifc.SrcB        = $urandom;
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({ifc.in_ready, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b ill=%b",
                     ifc.in_ready, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_sub();
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1);
        total_cnt++;
        if ({ifc.out_valid, ifc.in_ready, ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0})
            $display("FAIL add_wrap: got vld=%b rdy=%b res=%h z=%b ill=%b, need 1 0 00000000 1 0",
                     ifc.out_valid, ifc.in_ready, ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        drain();
        total_cnt++;
        if ({ifc.out_valid, ifc.in_ready} !== 2'b01)
            $display("FAIL add_handshake: got vld=%b rdy=%b, need 0 1", ifc.out_valid, ifc.in_ready);
        else pass_cnt++;
        issue(4'b0001, 32'd5, 32'd7);
        total_cnt++;
        if ({ifc.out_valid, ifc.ALUResult, ifc.Zero} !== {1'b1, 32'hFFFF_FFFE, 1'b0})
            $display("FAIL sub_neg: got vld=%b res=%h z=%b, need 1 fffffffe 0",
                     ifc.out_valid, ifc.ALUResult, ifc.Zero);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_cmp_shift();
        vec_t v[$];
        v.push_back('{4'b0101, 32'hFFFF_FFFF, 32'd1,          32'd1});
        v.push_back('{4'b0110, 32'hFFFF_FFFF, 32'd1,          32'd0});
        v.push_back('{4'b1011, 32'h8000_0000, 32'h0000_0025,  32'hFC00_0000});
        v.push_back('{4'b1100, 32'h8000_0000, 32'h0000_0025,  32'h0400_0000});
        v.push_back('{4'b1010, 32'd1,         32'd31,         32'h8000_0000});
        v.push_back('{4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'h00F0_00F0});
        v.push_back('{4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFFF0_FFF0});
        foreach (v[i]) begin
            issue(v[i].c, v[i].a, v[i].b);
            total_cnt++;
            if ({ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !==
                {1'b1, v[i].r, (v[i].r == 32'd0), 1'b0})
                $display("FAIL cmp_shift[%0d] op=%b: got vld=%b res=%h z=%b ill=%b, need res=%h",
                         i, v[i].c, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal, v[i].r);
            else pass_cnt++;
            drain();
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic bad;
        v.push_back('{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        v.push_back('{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        v.push_back('{4'b1001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        v.push_back('{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000});
        v.push_back('{4'b1000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
        v.push_back('{4'b1001, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF});
        foreach (v[i]) begin
            issue(v[i].c, v[i].a, v[i].b);
            bad = 1'b0;
            repeat (32) begin
                @(posedge clk);
                #1;
                if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0) bad = 1'b1;
            end
            total_cnt++;
            if (bad !== 1'b0)
                $display("FAIL mul_busy[%0d]: out_valid or in_ready high before cycle 33", i);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !==
                {1'b1, v[i].r, (v[i].r == 32'd0), 1'b0})
                $display("FAIL mul[%0d] op=%b: got vld=%b res=%h z=%b ill=%b, need vld=1 res=%h",
                         i, v[i].c, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal, v[i].r);
            else pass_cnt++;
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        issue(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        bad = 1'b0;
        repeat (10) begin
            if ({ifc.out_valid, ifc.in_ready, ifc.ALUResult, ifc.Zero} !== {1'b1, 1'b0, 32'hFF00_FF00, 1'b0})
                bad = 1'b1;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (bad !== 1'b0 || ifc.ALUResult !== 32'hFF00_FF00 || ifc.out_valid !== 1'b1)
            $display("FAIL backpressure_hold: got vld=%b res=%h unstable=%b, need 1 ff00ff00 0",
                     ifc.out_valid, ifc.ALUResult, bad);
        else pass_cnt++;
        drain();
        total_cnt++;
        if ({ifc.out_valid, ifc.in_ready} !== 2'b01)
            $display("FAIL backpressure_release: got vld=%b rdy=%b, need 0 1", ifc.out_valid, ifc.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        logic bad;
        issue(4'b1000, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total_cnt++;
        if ({ifc.in_ready, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
            $display("FAIL mid_mul_reset: got rdy=%b vld=%b res=%h z=%b ill=%b, need 1 0 0 0 0",
                     ifc.in_ready, ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid !== 1'b0) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0)
            $display("FAIL mid_mul_ghost: got out_valid=1 after reset, need 0");
        else pass_cnt++;
        issue(4'b0000, 32'd2, 32'd3);
        total_cnt++;
        if ({ifc.out_valid, ifc.ALUResult} !== {1'b1, 32'd5})
            $display("FAIL post_reset_add: got vld=%b res=%h, need 1 00000005", ifc.out_valid, ifc.ALUResult);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_illegal();
        issue(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0);
        total_cnt++;
        if ({ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {1'b1, 32'd0, 1'b1, 1'b1})
            $display("FAIL illegal_0111: got vld=%b res=%h z=%b ill=%b, need 1 0 1 1",
                     ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        drain();
        issue(4'b1111, 32'hFFFF_FFFF, 32'h0000_0003);
        total_cnt++;
        if ({ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {1'b1, 32'd0, 1'b1, 1'b1})
            $display("FAIL illegal_1111: got vld=%b res=%h z=%b ill=%b, need 1 0 1 1",
                     ifc.out_valid, ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        drain();
        issue(4'b0100, 32'h0000_00FF, 32'h0000_000F);
        total_cnt++;
        if ({ifc.ALUResult, ifc.Zero, ifc.Illegal} !== {32'h0000_00F0, 1'b0, 1'b0})
            $display("FAIL illegal_clear: got res=%h z=%b ill=%b, need 000000f0 0 0",
                     ifc.ALUResult, ifc.Zero, ifc.Illegal);
        else pass_cnt++;
        drain();
    endtask

    // in_valid and out_ready both held high: accepts and completions must
    // alternate, never overlapping in the same cycle.
    task automatic test_back_to_back();
        logic [5:0] seen;
        ifc.in_valid    = 1'b1;
        ifc.ALU_Control = 4'b0000;
        ifc.SrcA        = 32'd10;
        ifc.SrcB        = 32'd20;
        ifc.out_ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen[i] = ifc.out_valid;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        total_cnt++;
        if (seen !== 6'b010101)
            $display("FAIL back_to_back: got out_valid pattern %b (edge0 at lsb), need 010101", seen);
        else pass_cnt++;
        total_cnt++;
        if (ifc.ALUResult !== 32'd30)
            $display("FAIL back_to_back_res: got %h, need 0000001e", ifc.ALUResult);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst_n           = 1'b0;
        ifc.in_valid    = 1'b0;
        ifc.ALU_Control = 4'd0;
        ifc.SrcA        = 32'd0;
        ifc.SrcB        = 32'd0;
        ifc.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_sub();
        test_cmp_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage unit for the RV32I core that consumes the 4-bit ALU_Control code produced by the ALU decoder and performs the operation on two 32-bit operands. Base ALU operations complete in one cycle. The MUL/MULH codes run an iterative radix-2 shift-add multiplier over 32 cycles. Operations enter and leave through a valid/ready handshake on each side, so the pipeline can stall on multiplies and on downstream backpressure.

## Interface
- XLEN, 32, operand/result width (fixed at 32; not intended to be varied)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation (high only in IDLE)
- ALU_Control  in  4  operation code, sampled on accept
- SrcA  in  32  operand A, sampled on accept
- SrcB  in  32  operand B, sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- ALUResult  out  32  registered result
- Zero  out  1  registered (ALUResult == 0)
- Illegal  out  1  registered flag: unsupported code was accepted

## Operation
- Codes:
  - 0000 ADD A+B (mod 2^32)
  - 0001 SUB A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT signed A<B → 1/0
  - 0110 SLTU unsigned A<B → 1/0
  - 1010 SLL A<<B[4:0]
  - 1011 SRA arithmetic A>>>B[4:0]
  - 1100 SRL logical A>>B[4:0]
  - 1000 MUL low 32 of signed A×B
  - 1001 MULH high 32 of signed×signed A×B
- Codes 0111, 1101, 1110, 1111 are unsupported:
  - ALUResult=0, Zero=1, Illegal=1.
  - Handled as a single-cycle op.
- Illegal=0 for every supported code.
- Shifts use only B[4:0]; B[31:5] is ignored.
- States: IDLE, MUL, FIX, RESP.
- IDLE: in_ready=1.
  - Accept on in_valid & in_ready.
  - Single-cycle or unsupported code: register result/Zero/Illegal → RESP.
  - 1000/1001: load |A|, |B| (unsigned magnitude; 0x80000000 → 0x80000000), record sign = A[31]^B[31], clear 64-bit product, count=0, latch high/low select → MUL.
- MUL: one shift-add iteration per cycle on the 64-bit accumulator.
  - count increments each cycle.
  - After the iteration with count=31 → FIX.
- FIX: product is negated (two's complement, 64-bit) if sign=1.
  - ALUResult ← product[31:0] for MUL, product[63:32] for MULH.
  - Zero and Illegal=0 registered → RESP.
- RESP: out_valid=1. ALUResult/Zero/Illegal are held stable until out_valid & out_ready, then → IDLE.
- in_ready=0 in MUL, FIX and RESP. No accept occurs in the cycle a result leaves.
- in_valid/ALU_Control/SrcA/SrcB are don't-care outside accept cycles. Inputs changing during MUL do not affect the result.

## Timing
- Reset (rst_n=0 at a clock edge), next edge state and outputs:
  - state=IDLE, in_ready=1, out_valid=0.
  - ALUResult=0, Zero=0, Illegal=0, count=0.
- Reset mid-operation (MUL, FIX, RESP):
  - The operation is abandoned and no result is produced.
  - The unit is in IDLE after the edge.
- Single-cycle latency: accept at edge N → out_valid=1 from edge N+1.
- Multiply latency: accept at edge N → MUL for edges N+1..N+32 → FIX at edge N+33 → out_valid=1 from edge N+33.
  - Fixed 33 cycles, independent of operand values.
- Backpressure: out_ready=0 holds RESP indefinitely with outputs constant.
- Throughput: at best one single-cycle op every 2 cycles (out_ready held high).
- All outputs are registered. There is no combinational path from in_* to out_* or from out_ready to in_ready.

## Test plan
- Reset then ADD:
  - Inputs: ADD SrcA=0xFFFFFFFF, SrcB=1.
  - Required: out_valid one cycle after accept, ALUResult=0x00000000, Zero=1, Illegal=0.
  - Then SUB 5-7 → 0xFFFFFFFE, Zero=0.
- Compare and shift:
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU same operands → 0.
  - SRA 0x80000000, SrcB=0x25 → 0xFC000000 (shift amount 5).
  - SRL same → 0x04000000.
  - SLL 1, SrcB=31 → 0x80000000.
- Multiply:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - MULH same → 0x00000000.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MUL 0x00010000×0x00010000 → 0, Zero=1.
  - Each result appears exactly 33 cycles after accept; in_ready=0 throughout.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after an XOR 0xF0F0F0F0^0x0FF00FF0.
  - Required: out_valid stays 1, ALUResult=0xFF00FF00 stable, in_ready=0.
  - Raise out_ready: one-cycle handshake, then in_ready=1.
- Reset mid-multiply:
  - Drive rst_n=0 for one edge at MUL cycle 10.
  - Required: out_valid never rises, outputs take reset values, next ADD 2+3 returns 5 with latency 1.
- Unsupported code:
  - ALU_Control=0111 with arbitrary operands.
  - Required: ALUResult=0, Zero=1, Illegal=1, latency 1.
  - Next supported op clears Illegal.
